// File: rtl/fwuart_rx.sv
// fwuart_rx: 16x-oversampling UART receiver with valid/ready holding register.
// Optional parity check enabled by defining FWUART_RX_PARITY_EN.
module fwuart_rx #(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 clock_x16,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
`ifdef FWUART_RX_PARITY_EN
  ,
  input  logic                 parity_odd,
  output logic                 parity_err
`endif
);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [BW-1:0] LAST = BW'(DATA_BITS - 1);

`ifdef FWUART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;
`endif

  state_t                r_state, w_nstate;
  logic                  r_sync1, r_sync2;
  logic [3:0]            r_tcnt, w_tcnt;
  logic [BW-1:0]         r_bcnt, w_bcnt;
  logic                  r_stop2, w_stop2;
  logic [DATA_BITS-1:0]  r_shift;
  logic [DATA_BITS-1:0]  r_rx_data;
  logic                  r_rx_valid, r_frame_err, r_overrun;
  logic                  w_sample, w_done, w_ferr, w_load;
`ifdef FWUART_RX_PARITY_EN
  logic                  r_pbit, r_parity_err, w_psample, w_pbad;
`endif

  always_comb begin
    w_nstate  = r_state;
    w_tcnt    = r_tcnt;
    w_bcnt    = r_bcnt;
    w_stop2   = r_stop2;
    w_sample  = 1'b0;
    w_done    = 1'b0;
    w_ferr    = 1'b0;
`ifdef FWUART_RX_PARITY_EN
    w_psample = 1'b0;
`endif
    if (clock_x16) begin
      case (r_state)
        S_IDLE: if (!r_sync2) begin
          w_nstate = S_START;
          w_tcnt   = 4'd0;
        end
        S_START: if (r_tcnt == 4'd7) begin
          w_nstate = r_sync2 ? S_IDLE : S_DATA;
          w_tcnt   = 4'd0;
          w_bcnt   = '0;
        end else w_tcnt = r_tcnt + 4'd1;
        S_DATA: begin
          w_tcnt = r_tcnt + 4'd1;
          if (r_tcnt == 4'd15) begin
            w_sample = 1'b1;
            w_bcnt   = r_bcnt + BW'(1);
            w_stop2  = 1'b0;
`ifdef FWUART_RX_PARITY_EN
            if (r_bcnt == LAST) w_nstate = S_PARITY;
`else
            if (r_bcnt == LAST) w_nstate = S_STOP;
`endif
          end
        end
`ifdef FWUART_RX_PARITY_EN
        S_PARITY: begin
          w_tcnt = r_tcnt + 4'd1;
          if (r_tcnt == 4'd15) begin
            w_psample = 1'b1;
            w_nstate  = S_STOP;
          end
        end
`endif
        S_STOP: begin
          w_tcnt = r_tcnt + 4'd1;
          if (r_tcnt == 4'd15) begin
            if (!r_sync2) begin
              w_ferr   = 1'b1;
              w_nstate = S_BREAK;
            end else if (STOP_BITS == 2 && !r_stop2) w_stop2 = 1'b1;
            else begin
              w_done   = 1'b1;
              w_nstate = S_IDLE;
            end
          end
        end
        S_BREAK: if (r_sync2) w_nstate = S_IDLE;
        default: w_nstate = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_tcnt  <= 4'd0;
      r_bcnt  <= '0;
      r_stop2 <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_tcnt  <= w_tcnt;
      r_bcnt  <= w_bcnt;
      r_stop2 <= w_stop2;
    end
  end

  // A completing frame may reload the holding register in the same cycle it is consumed.
  assign w_load = w_done && (!r_rx_valid || rx_ready);
`ifdef FWUART_RX_PARITY_EN
  assign w_pbad = (^r_shift ^ parity_odd) != r_pbit;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1      <= 1'b1;
      r_sync2      <= 1'b1;
      r_shift      <= '0;
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
`ifdef FWUART_RX_PARITY_EN
      r_pbit       <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_sync1     <= rx;
      r_sync2     <= r_sync1;
      if (w_sample) r_shift[r_bcnt] <= r_sync2;
      r_rx_data   <= w_load ? r_shift : r_rx_data;
      r_rx_valid  <= w_load | (r_rx_valid & ~rx_ready);
      r_frame_err <= w_ferr;
      r_overrun   <= w_done & r_rx_valid & ~rx_ready;
`ifdef FWUART_RX_PARITY_EN
      if (w_psample) r_pbit <= r_sync2;
      r_parity_err <= (w_done | w_ferr) & w_pbad;
`endif
    end
  end

  assign rx_data    = r_rx_data;
  assign rx_valid   = r_rx_valid;
  assign frame_err  = r_frame_err;
  assign overrun    = r_overrun;
  assign busy       = r_state != S_IDLE;
`ifdef FWUART_RX_PARITY_EN
  assign parity_err = r_parity_err;
`endif
endmodule

// File: tb/tb_fwuart_rx.sv
// tb_fwuart_rx: directed and randomized frames checked against a frame-level model.
module tb_fwuart_rx;
  logic       clock = 1'b0, reset_n = 1'b0, clock_x16 = 1'b0, rx = 1'b1, rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun, busy;
`ifdef FWUART_RX_PARITY_EN
  logic       parity_odd = 1'b0, parity_err;
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  // Start seen 2 sync clocks + 1 tick after the line falls, then 8 ticks to mid-start,
  // then 16 ticks (64 clocks) per bit; the last stop sample lands on this step.
  localparam int DONE_S = 36 + 64 * (FB - 1);

  int n_vec = 0, n_bad = 0, ph = 0;
  int n_rise = 0, n_hi = 0, n_ferr = 0, n_ovr = 0, n_perr = 0;
  int b_rise, b_hi, b_ferr, b_ovr, b_perr;
  logic [7:0] last_data = 8'h00;
  logic pv = 1'b0;

  fwuart_rx dut (
    .clock(clock), .reset_n(reset_n), .clock_x16(clock_x16), .rx(rx),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .frame_err(frame_err), .overrun(overrun), .busy(busy)
`ifdef FWUART_RX_PARITY_EN
    , .parity_odd(parity_odd), .parity_err(parity_err)
`endif
  );

  always #5 clock = ~clock;

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial forever begin
    @(negedge clock);
    if (rx_valid && !pv) begin
      n_rise++;
      last_data = rx_data;
    end
    if (rx_valid) n_hi++;
    if (frame_err) n_ferr++;
    if (overrun) n_ovr++;
`ifdef FWUART_RX_PARITY_EN
    if (parity_err) n_perr++;
`endif
    pv = rx_valid;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
    clock_x16 = (ph == 0);
    ph = (ph + 1) % 4;
  endtask

  task automatic snap();
    b_rise = n_rise; b_hi = n_hi; b_ferr = n_ferr; b_ovr = n_ovr; b_perr = n_perr;
  endtask

  task automatic ev_chk(input string tag, input int rise, input int ferr, input int ovr);
    chk({tag, "_rise"}, n_rise - b_rise, rise);
    chk({tag, "_ferr"}, n_ferr - b_ferr, ferr);
    chk({tag, "_ovr"}, n_ovr - b_ovr, ovr);
  endtask

  task automatic send(input logic [7:0] d, input logic stop_lvl, input logic par_lvl,
                      input bit pulse, input int abort_at);
    logic [10:0] fr;
    fr = '0;
    fr[8:1] = d;
`ifdef FWUART_RX_PARITY_EN
    fr[9] = par_lvl;
    fr[10] = stop_lvl;
`else
    fr[9] = stop_lvl;
    fr[10] = par_lvl;
`endif
    do step(); while (!clock_x16);
    for (int s = 0; s < 64 * FB; s++) begin
      if (s == abort_at) begin
        reset_n = 1'b0;
        #1;
        chk("rst_valid", rx_valid, 0);
        chk("rst_data", rx_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_ovr", overrun, 0);
        rx = 1'b1;
        repeat (3) step();
        reset_n = 1'b1;
        return;
      end
      if (s % 64 == 0) rx = fr[s/64];
      if (pulse) rx_ready = (s == DONE_S);
      step();
    end
  endtask

  logic [7:0] d;
  logic       r, mv;
  logic [7:0] md;

  initial begin
    repeat (3) step();
    chk("reset_valid", rx_valid, 0);
    chk("reset_data", rx_data, 0);
    chk("reset_ferr", frame_err, 0);
    chk("reset_ovr", overrun, 0);
    chk("reset_busy", busy, 0);
    reset_n = 1'b1;
    repeat (10) step();

    rx_ready = 1'b1;
    snap();
    send(8'hA5, 1'b1, ^8'hA5, 1'b0, -1);
    repeat (16) step();
    ev_chk("a5", 1, 0, 0);
    chk("a5_data", last_data, 8'hA5);
    chk("a5_hi", n_hi - b_hi, 1);
    chk("a5_valid", rx_valid, 0);

    snap();
    step();
    rx = 1'b0;
    repeat (24) step();
    rx = 1'b1;
    repeat (200) step();
    chk("glitch_busy", busy, 0);
    ev_chk("glitch", 0, 0, 0);
    send(8'h3C, 1'b1, ^8'h3C, 1'b0, -1);
    repeat (16) step();
    ev_chk("g3c", 1, 0, 0);
    chk("g3c_data", last_data, 8'h3C);

    snap();
    send(8'h55, 1'b0, ^8'h55, 1'b0, -1);
    repeat (20 * 64) step();
    chk("brk_busy", busy, 1);
    rx = 1'b1;
    repeat (100) step();
    chk("brk_idle", busy, 0);
    ev_chk("brk", 0, 1, 0);
    snap();
    send(8'h81, 1'b1, ^8'h81, 1'b0, -1);
    repeat (16) step();
    ev_chk("b81", 1, 0, 0);
    chk("b81_data", last_data, 8'h81);

    rx_ready = 1'b0;
    snap();
    send(8'h11, 1'b1, ^8'h11, 1'b0, -1);
    repeat (16) step();
    chk("ov11_valid", rx_valid, 1);
    chk("ov11_data", rx_data, 8'h11);
    send(8'h22, 1'b1, ^8'h22, 1'b0, -1);
    repeat (16) step();
    ev_chk("ov22", 1, 0, 1);
    chk("ov22_data", rx_data, 8'h11);
    chk("ov22_valid", rx_valid, 1);
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
    step();
    chk("drain_valid", rx_valid, 0);
    send(8'h11, 1'b1, ^8'h11, 1'b0, -1);
    repeat (16) step();
    snap();
    send(8'h22, 1'b1, ^8'h22, 1'b1, -1);
    repeat (16) step();
    ev_chk("race", 0, 0, 0);
    chk("race_data", rx_data, 8'h22);
    chk("race_valid", rx_valid, 1);

    send(8'h5A, 1'b1, ^8'h5A, 1'b0, -1);
    repeat (16) step();
    send(8'hF0, 1'b1, ^8'hF0, 1'b0, 64 * 3 + 10);
    repeat (100) step();
    chk("post_rst_busy", busy, 0);
    rx_ready = 1'b1;
    snap();
    send(8'h0F, 1'b1, ^8'h0F, 1'b0, -1);
    repeat (16) step();
    ev_chk("r0f", 1, 0, 0);
    chk("r0f_data", last_data, 8'h0F);

    mv = 1'b0;
    md = 8'h00;
    for (int i = 0; i < 10; i++) begin
      d = 8'($urandom);
      r = 1'($urandom_range(0, 1));
      rx_ready = r;
      snap();
      send(d, 1'b1, ^d, 1'b0, -1);
      repeat (16) step();
      if (r) begin
        mv = 1'b0;
        ev_chk("rnd_rdy", 1, 0, 0);
        chk("rnd_rdy_data", last_data, d);
      end else if (mv) begin
        ev_chk("rnd_full", 0, 0, 1);
      end else begin
        mv = 1'b1;
        md = d;
        ev_chk("rnd_load", 1, 0, 0);
      end
      chk("rnd_valid", rx_valid, mv);
      if (mv) chk("rnd_hold", rx_data, md);
    end

`ifdef FWUART_RX_PARITY_EN
    parity_odd = 1'b0;
    rx_ready = 1'b1;
    repeat (4) step();
    snap();
    send(8'h07, 1'b1, 1'b1, 1'b0, -1);
    repeat (16) step();
    chk("par_ok_perr", n_perr - b_perr, 0);
    chk("par_ok_data", last_data, 8'h07);
    snap();
    send(8'h07, 1'b1, 1'b0, 1'b0, -1);
    repeat (16) step();
    chk("par_bad_perr", n_perr - b_perr, 1);
    ev_chk("par_bad", 1, 0, 0);
    chk("par_bad_data", last_data, 8'h07);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
